// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU dispatch block: widths, opcodes, instruction
// field positions and the controller state encoding.
package alu_dispatch_pkg;

   localparam int DW    = 16;
   localparam int NREG  = 8;
   localparam int IMM_W = 6;
   localparam int RAW   = 3;

   localparam logic [2:0] OP_SHIFT = 3'b000;
   localparam logic [2:0] OP_RSV1  = 3'b001;
   localparam logic [2:0] OP_RSV2  = 3'b010;
   localparam logic [2:0] OP_RSV3  = 3'b011;
   localparam logic [2:0] OP_ADD   = 3'b100;
   localparam logic [2:0] OP_AND   = 3'b101;
   localparam logic [2:0] OP_OR    = 3'b110;
   localparam logic [2:0] OP_NOT   = 3'b111;

   localparam int OP_HI   = 15;
   localparam int OP_LO   = 13;
   localparam int RD_HI   = 12;
   localparam int RD_LO   = 10;
   localparam int RS1_HI  = 9;
   localparam int RS1_LO  = 7;
   localparam int IMM_SEL = 6;
   localparam int RS2_HI  = 5;
   localparam int RS2_LO  = 3;
   localparam int IMM_HI  = 5;
   localparam int IMM_LO  = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WB    = 2'd2
   } state_e;

   function automatic logic [DW-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

   function automatic logic op_is_illegal(input logic [2:0] op);
      return (op == OP_RSV1) || (op == OP_RSV2) || (op == OP_RSV3);
   endfunction

endpackage

// File: rtl/alu_dispatch_regfile.sv
// 8x16 register file with two combinational read ports and a write path that
// merges write-back and external loads.
module alu_dispatch_regfile
   import alu_dispatch_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic [RAW-1:0] rd_addr1,
   output logic [DW-1:0]  rd_data1,
   input  logic [RAW-1:0] rd_addr2,
   output logic [DW-1:0]  rd_data2,
   input  logic           wb_en,
   input  logic [RAW-1:0] wb_addr,
   input  logic [DW-1:0]  wb_data,
   input  logic           ld_en,
   input  logic [RAW-1:0] ld_addr,
   input  logic [DW-1:0]  ld_data
);

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];

   assign rd_data1 = regs_q[rd_addr1];
   assign rd_data2 = regs_q[rd_addr2];

   // Write-back is applied last so it overrides a load aimed at the same register.
   always_comb begin
      regs_d = regs_q;
      if (ld_en) begin
         regs_d[ld_addr] = ld_data;
      end
      if (wb_en) begin
         regs_d[wb_addr] = wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: rtl/alu_dispatch.sv
// Issue-side controller: accepts one instruction, drives the external ALU for a
// cycle from registered operands, then writes the captured result back.
module alu_dispatch
   import alu_dispatch_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           instr_valid,
   output logic           instr_ready,
   input  logic [DW-1:0]  instr,
   input  logic           ld_en,
   input  logic [RAW-1:0] ld_addr,
   input  logic [DW-1:0]  ld_data,
   output logic [DW-1:0]  alu_operand1,
   output logic [DW-1:0]  alu_operand2,
   output logic [2:0]     alu_operation,
   input  logic [DW-1:0]  alu_result,
   output logic           res_valid,
   output logic [RAW-1:0] res_rd,
   output logic [DW-1:0]  res_data,
   output logic           illegal
);

   state_e         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [RAW-1:0] rd_q, rd_d;
   logic           instr_ready_q, instr_ready_d;
   logic [DW-1:0]  operand1_q, operand1_d;
   logic [DW-1:0]  operand2_q, operand2_d;
   logic [2:0]     operation_q, operation_d;
   logic           res_valid_q, res_valid_d;
   logic [RAW-1:0] res_rd_q, res_rd_d;
   logic [DW-1:0]  res_data_q, res_data_d;
   logic           illegal_q, illegal_d;

   logic [DW-1:0]  rs1_data;
   logic [DW-1:0]  rs2_data;

   // Register file writes only in WB, straight from the registered result outputs.
   alu_dispatch_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rd_addr1 (instr[RS1_HI:RS1_LO]),
      .rd_data1 (rs1_data),
      .rd_addr2 (instr[RS2_HI:RS2_LO]),
      .rd_data2 (rs2_data),
      .wb_en    (res_valid_q),
      .wb_addr  (res_rd_q),
      .wb_data  (res_data_q),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      rd_d          = rd_q;
      instr_ready_d = instr_ready_q;
      operand1_d    = operand1_q;
      operand2_d    = operand2_q;
      operation_d   = operation_q;
      res_valid_d   = 1'b0;
      res_rd_d      = res_rd_q;
      res_data_d    = res_data_q;
      illegal_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (instr_valid && instr_ready_q) begin
               state_d       = ST_ISSUE;
               instr_ready_d = 1'b0;
               op_d          = instr[OP_HI:OP_LO];
               rd_d          = instr[RD_HI:RD_LO];
               operand1_d    = rs1_data;
               operand2_d    = instr[IMM_SEL] ? sext_imm(instr[IMM_HI:IMM_LO]) : rs2_data;
               operation_d   = instr[OP_HI:OP_LO];
            end
         end
         // Illegal ops still exercise the ALU but never reach the register file.
         ST_ISSUE: begin
            state_d = ST_WB;
            if (op_is_illegal(op_q)) begin
               illegal_d = 1'b1;
            end else begin
               res_valid_d = 1'b1;
               res_rd_d    = rd_q;
               res_data_d  = alu_result;
            end
         end
         ST_WB: begin
            state_d       = ST_IDLE;
            instr_ready_d = 1'b1;
         end
         default: begin
            state_d       = ST_IDLE;
            instr_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         rd_q          <= '0;
         instr_ready_q <= 1'b1;
         operand1_q    <= '0;
         operand2_q    <= '0;
         operation_q   <= '0;
         res_valid_q   <= 1'b0;
         res_rd_q      <= '0;
         res_data_q    <= '0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         rd_q          <= rd_d;
         instr_ready_q <= instr_ready_d;
         operand1_q    <= operand1_d;
         operand2_q    <= operand2_d;
         operation_q   <= operation_d;
         res_valid_q   <= res_valid_d;
         res_rd_q      <= res_rd_d;
         res_data_q    <= res_data_d;
         illegal_q     <= illegal_d;
      end
   end

   assign instr_ready   = instr_ready_q;
   assign alu_operand1  = operand1_q;
   assign alu_operand2  = operand2_q;
   assign alu_operation = operation_q;
   assign res_valid     = res_valid_q;
   assign res_rd        = res_rd_q;
   assign res_data      = res_data_q;
   assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a behavioural ALU sits beside the DUT, and a register
// array model predicts operands, results and write-backs.
module tb_alu_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        ld_en;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic [15:0] alu_operand1;
   logic [15:0] alu_operand2;
   logic [2:0]  alu_operation;
   logic [15:0] alu_result;
   logic        res_valid;
   logic [2:0]  res_rd;
   logic [15:0] res_data;
   logic        illegal;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] ref_regs [8];

   always #5 clk = ~clk;

   // ALU behaviour written from the opcode table with plain integer arithmetic.
   function automatic logic [15:0] refAlu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
      int sb;
      case (op)
         3'b000: begin
            sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
            if (sb < 0) return a >> ((-sb) % 16);
            else        return a << (sb % 16);
         end
         3'b100:  return 16'((int'(a) + int'(b)) % 65536);
         3'b101:  return a & b;
         3'b110:  return a | b;
         3'b111:  return ~a;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] sextImm(input logic [5:0] imm);
      int v;
      v = (imm >= 6'd32) ? int'(imm) - 64 : int'(imm);
      return 16'(v);
   endfunction

   assign alu_result = refAlu(alu_operation, alu_operand1, alu_operand2);

   alu_dispatch dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .ld_en         (ld_en),
      .ld_addr       (ld_addr),
      .ld_data       (ld_data),
      .alu_operand1  (alu_operand1),
      .alu_operand2  (alu_operand2),
      .alu_operation (alu_operation),
      .alu_result    (alu_result),
      .res_valid     (res_valid),
      .res_rd        (res_rd),
      .res_data      (res_data),
      .illegal       (illegal)
   );

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic loadReg(input logic [2:0] addr, input logic [15:0] data);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = addr;
      ld_data = data;
      @(negedge clk);
      ld_en   = 1'b0;
      ref_regs[addr] = data;
   endtask

   // Presents an instruction and returns just after the handshake edge.
   task automatic applyStimulus(input logic [15:0] ins);
      int n = 0;
      @(negedge clk);
      while (instr_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ready_wait", {15'd0, instr_ready}, 16'd1);
      instr       = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr       = 16'($urandom);
   endtask

   task automatic runInstr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic imm_sel, input logic [5:0] low6, input bit collide);
      logic [15:0] exp_a, exp_b, exp_r;
      logic [2:0]  rs2;
      bit          legal;
      rs2   = low6[5:3];
      exp_a = ref_regs[rs1];
      exp_b = imm_sel ? sextImm(low6) : ref_regs[rs2];
      exp_r = refAlu(op, exp_a, exp_b);
      legal = !(op == 3'b001 || op == 3'b010 || op == 3'b011);
      applyStimulus({op, rd, rs1, imm_sel, low6});
      @(negedge clk);
      checkOutput("issue_operand1", alu_operand1, exp_a);
      checkOutput("issue_operand2", alu_operand2, exp_b);
      checkOutput("issue_operation", {13'd0, alu_operation}, {13'd0, op});
      checkOutput("issue_ready", {15'd0, instr_ready}, 16'd0);
      checkOutput("issue_res_valid", {15'd0, res_valid}, 16'd0);
      @(negedge clk);
      checkOutput("wb_res_valid", {15'd0, res_valid}, {15'd0, legal});
      checkOutput("wb_illegal", {15'd0, illegal}, {15'd0, !legal});
      checkOutput("wb_ready", {15'd0, instr_ready}, 16'd0);
      if (legal) begin
         checkOutput("wb_res_rd", {13'd0, res_rd}, {13'd0, rd});
         checkOutput("wb_res_data", res_data, exp_r);
      end
      if (collide) begin
         ld_en   = 1'b1;
         ld_addr = rd;
         ld_data = 16'hAAAA;
      end
      @(negedge clk);
      ld_en = 1'b0;
      checkOutput("post_res_valid", {15'd0, res_valid}, 16'd0);
      checkOutput("post_illegal", {15'd0, illegal}, 16'd0);
      checkOutput("post_ready", {15'd0, instr_ready}, 16'd1);
      checkOutput("post_operand1_hold", alu_operand1, exp_a);
      if (legal) ref_regs[rd] = exp_r;
   endtask

   task automatic readReg(input logic [2:0] r);
      runInstr(3'b110, r, r, 1'b1, 6'd0, 1'b0);
   endtask

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      ld_en       = 1'b0;
      ld_addr     = '0;
      ld_data     = '0;
      for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      checkOutput("rst_ready", {15'd0, instr_ready}, 16'd1);
      checkOutput("rst_res_valid", {15'd0, res_valid}, 16'd0);
      checkOutput("rst_illegal", {15'd0, illegal}, 16'd0);
      checkOutput("rst_operand1", alu_operand1, 16'h0000);
      checkOutput("rst_operand2", alu_operand2, 16'h0000);
      checkOutput("rst_operation", {13'd0, alu_operation}, 16'd0);
      checkOutput("rst_res_rd", {13'd0, res_rd}, 16'd0);
      checkOutput("rst_res_data", res_data, 16'h0000);

      loadReg(3'd1, 16'h7FFF);
      loadReg(3'd2, 16'h0001);
      runInstr(3'b100, 3'd3, 3'd1, 1'b0, {3'd2, 3'd0}, 1'b0);
      readReg(3'd3);

      loadReg(3'd1, 16'h00F0);
      runInstr(3'b000, 3'd4, 3'd1, 1'b1, 6'b111100, 1'b0);
      runInstr(3'b000, 3'd4, 3'd1, 1'b1, 6'd4, 1'b0);

      runInstr(3'b010, 3'd4, 3'd1, 1'b0, {3'd2, 3'd0}, 1'b0);
      readReg(3'd4);

      loadReg(3'd1, 16'h7FFF);
      loadReg(3'd3, 16'h1111);
      runInstr(3'b100, 3'd3, 3'd1, 1'b0, {3'd2, 3'd0}, 1'b1);
      readReg(3'd3);

      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            loadReg(3'($urandom_range(0, 7)), 16'($urandom));
         end
         runInstr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b0);
      end

      // Abort an instruction while the ALU is being driven.
      loadReg(3'd5, 16'h1234);
      applyStimulus({3'b100, 3'd6, 3'd5, 1'b1, 6'd1});
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready", {15'd0, instr_ready}, 16'd1);
      checkOutput("abort_res_valid", {15'd0, res_valid}, 16'd0);
      checkOutput("abort_operand1", alu_operand1, 16'h0000);
      @(negedge clk);
      checkOutput("abort_res_valid_late", {15'd0, res_valid}, 16'd0);
      checkOutput("abort_illegal_late", {15'd0, illegal}, 16'd0);
      for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
      for (int i = 0; i < 8; i++) readReg(3'(i));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
